// File: rtl/conv_sched_pkg.sv
// Shared types for the convolution frame scheduler: FSM states and the IQ beat layout.
package conv_sched_pkg;

    localparam int SAMPLE_W = 16;

    // Two 16-bit samples per beat, each sample split into two bytes.
    typedef logic [1:0][1:0][7:0] iq_beat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } sched_state_t;

endpackage

// File: rtl/sched_out_tracker.sv
// Output side of the frame scheduler: registers lyr3 results, counts them per frame,
// tags the last one and flags outputs beyond the per-frame quota.
module sched_out_tracker
    import conv_sched_pkg::*;
#(
    parameter int OUT_PER_FRAME = 1024,
    parameter int OUT_W         = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  sched_state_t     state,
    input  logic             clr,
    input  logic             err_clr,
    input  logic             pipe_vld_out,
    input  logic [OUT_W-1:0] pipe_data_out,
    output logic             out_vld,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             out_full,
    output logic             hit_last,
    output logic             err_flag
);

    localparam int CNT_W = $clog2(OUT_PER_FRAME + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUT_PER_FRAME);

    logic [CNT_W-1:0] out_cnt;
    logic             err_sticky;
    logic             active;
    logic             fwd;
    logic             ovr_now;

    assign active   = (state == FEED) || (state == DRAIN);
    assign out_full = (out_cnt == CNT_MAX);
    assign fwd      = active & pipe_vld_out & ~out_full;
    assign hit_last = fwd & (out_cnt == (CNT_MAX - 1'b1));
    assign ovr_now  = active & pipe_vld_out & out_full;
    // An overrun in the very cycle the frame closes must still be reported.
    assign err_flag = err_sticky | ovr_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld    <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_cnt    <= '0;
            err_sticky <= 1'b0;
        end else begin
            out_vld  <= fwd;
            out_last <= hit_last;
            if (fwd)
                out_data <= pipe_data_out;

            if (clr)
                out_cnt <= '0;
            else if (fwd)
                out_cnt <= out_cnt + 1'b1;

            if (err_clr)
                err_sticky <= 1'b0;
            else if (ovr_now)
                err_sticky <= 1'b1;
        end
    end

endmodule

// File: rtl/conv_frame_sched.sv
// Frame scheduler for the lyr1->lyr2->lyr3 pipeline: gates FRAME_LEN input beats per frame,
// waits for the frame's outputs (or a timeout) and resets the layers between frames.
//
// state | meaning
// IDLE  | waiting for start, input blocked
// FEED  | accepting input beats into lyr1
// DRAIN | input done, waiting for remaining lyr3 outputs or timeout
// FLUSH | holding lyr_rst for RST_CYCLES cycles
module conv_frame_sched
    import conv_sched_pkg::*;
#(
    parameter int FRAME_LEN     = 1024,
    parameter int OUT_PER_FRAME = 1024,
    parameter int DRAIN_TIMEOUT = 4096,
    parameter int RST_CYCLES    = 4,
    parameter int OUT_W         = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cont,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [2*SAMPLE_W-1:0] in_data,
    output logic                  lyr_rst,
    output logic                  lyr_vld_in,
    output logic [2*SAMPLE_W-1:0] lyr_data_in,
    input  logic                  pipe_vld_out,
    input  logic [OUT_W-1:0]      pipe_data_out,
    output logic                  out_vld,
    output logic [OUT_W-1:0]      out_data,
    output logic                  out_last,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int IN_W  = $clog2(FRAME_LEN + 1);
    localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam int FL_W  = $clog2(RST_CYCLES + 1);

    sched_state_t     state, state_nxt;
    logic [IN_W-1:0]  in_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [FL_W-1:0]  fl_cnt;
    logic             post_rst;
    iq_beat_t         lyr_beat;

    logic accept, in_last, tmo_hit, fl_last, flush_exit;
    logic out_full, hit_last, err_flag;

    assign accept  = in_vld & in_rdy;
    assign in_last = (in_cnt == IN_W'(FRAME_LEN - 1));
    assign tmo_hit = (tmo_cnt == TMO_W'(DRAIN_TIMEOUT - 1));
    assign fl_last = (fl_cnt == FL_W'(RST_CYCLES - 1));

    assign lyr_rst     = rst | (state == FLUSH);
    assign busy        = (state != IDLE);
    assign lyr_data_in = lyr_beat;

    always_comb begin
        state_nxt  = state;
        in_rdy     = 1'b0;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        flush_exit = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = FEED;
            end
            FEED: begin
                in_rdy = 1'b1;
                if (accept && in_last)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (out_full || tmo_hit) begin
                    state_nxt  = FLUSH;
                    frame_done = 1'b1;
                    // Last output landing together with the timeout counts as success.
                    frame_err  = err_flag | (tmo_hit & ~out_full & ~hit_last);
                end
            end
            FLUSH: begin
                if (fl_last) begin
                    flush_exit = 1'b1;
                    state_nxt  = (cont && !post_rst) ? FEED : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset lands in FLUSH so the layers stay in reset for RST_CYCLES after rst falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FLUSH;
            in_cnt     <= '0;
            tmo_cnt    <= '0;
            fl_cnt     <= '0;
            post_rst   <= 1'b1;
            lyr_vld_in <= 1'b0;
            lyr_beat   <= '0;
        end else begin
            state      <= state_nxt;
            lyr_vld_in <= accept;
            if (accept)
                lyr_beat <= in_data;

            if (flush_exit)
                in_cnt <= '0;
            else if (accept)
                in_cnt <= in_cnt + 1'b1;

            tmo_cnt <= (state == DRAIN) ? tmo_cnt + 1'b1 : '0;
            fl_cnt  <= (state == FLUSH && !fl_last) ? fl_cnt + 1'b1 : '0;

            if (flush_exit)
                post_rst <= 1'b0;
        end
    end

    sched_out_tracker #(
        .OUT_PER_FRAME (OUT_PER_FRAME),
        .OUT_W         (OUT_W)
    ) u_out_tracker (
        .clk           (clk),
        .rst           (rst),
        .state         (state),
        .clr           (flush_exit),
        .err_clr       (frame_done),
        .pipe_vld_out  (pipe_vld_out),
        .pipe_data_out (pipe_data_out),
        .out_vld       (out_vld),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_full      (out_full),
        .hit_last      (hit_last),
        .err_flag      (err_flag)
    );

endmodule

// File: tb/tb_conv_frame_sched.sv
// Bench for conv_frame_sched with the layer pipeline stubbed as an 8-cycle echo.
module tb_conv_frame_sched;

    localparam int FL    = 16;
    localparam int OPF   = 16;
    localparam int TMO   = 64;
    localparam int RC    = 4;
    localparam int OUT_W = 256;

    logic             clk = 1'b0;
    logic             rst, start, cont, in_vld, in_rdy;
    logic [31:0]      in_data;
    logic             lyr_rst, lyr_vld_in;
    logic [31:0]      lyr_data_in;
    logic             pipe_vld_out;
    logic [OUT_W-1:0] pipe_data_out;
    logic             out_vld, out_last, frame_done, frame_err, busy;
    logic [OUT_W-1:0] out_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    conv_frame_sched #(
        .FRAME_LEN(FL), .OUT_PER_FRAME(OPF), .DRAIN_TIMEOUT(TMO), .RST_CYCLES(RC), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .lyr_rst(lyr_rst), .lyr_vld_in(lyr_vld_in), .lyr_data_in(lyr_data_in),
        .pipe_vld_out(pipe_vld_out), .pipe_data_out(pipe_data_out),
        .out_vld(out_vld), .out_data(out_data), .out_last(out_last),
        .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
    );

    // Pipeline stub: 8-cycle delay line, optionally dropping its last 3 outputs or adding one.
    logic        stub_drop3 = 1'b0;
    logic        stub_extra = 1'b0;
    logic [7:0]  dl_vld;
    logic [31:0] dl_dat [8];
    int          stub_idx;
    logic        extra_pend;

    always @(posedge clk) begin
        if (lyr_rst) begin
            dl_vld     <= '0;
            stub_idx   <= 0;
            extra_pend <= 1'b0;
        end else begin
            dl_vld <= {dl_vld[6:0], lyr_vld_in};
            for (int i = 7; i > 0; i--) dl_dat[i] <= dl_dat[i-1];
            dl_dat[0]  <= lyr_data_in;
            extra_pend <= 1'b0;
            if (dl_vld[7]) begin
                stub_idx <= stub_idx + 1;
                if (stub_extra && stub_idx == OPF - 1) extra_pend <= 1'b1;
            end
        end
    end

    assign pipe_vld_out  = (dl_vld[7] && !(stub_drop3 && stub_idx >= OPF - 3)) || extra_pend;
    assign pipe_data_out = {224'b0, (extra_pend ? 32'hDEADBEEF : dl_dat[7])};

    // Observation of the DUT outputs, sampled on the falling edge.
    logic [31:0] out_q[$];
    int          last_idx[$];
    int          rst_runs[$];
    int          hi_nz = 0, n_lyr = 0, n_done = 0, drain_cnt = 0, last_drain = 0, run = 0;
    logic        last_err = 1'b0;

    always @(negedge clk) begin
        if (out_vld) begin
            out_q.push_back(out_data[31:0]);
            if (out_data[OUT_W-1:32] != '0) hi_nz <= hi_nz + 1;
            if (out_last) last_idx.push_back(out_q.size());
        end
        if (lyr_vld_in) n_lyr <= n_lyr + 1;
        if (rst) drain_cnt <= 0;
        else if (frame_done) begin
            n_done     <= n_done + 1;
            last_err   <= frame_err;
            last_drain <= drain_cnt + 1;
            drain_cnt  <= 0;
        end else if (busy && !in_rdy && !lyr_rst)
            drain_cnt <= drain_cnt + 1;
        if (lyr_rst && !rst) run <= run + 1;
        else begin
            if (run != 0) rst_runs.push_back(run);
            run <= 0;
        end
    end

    // Reference model: the frame's accepted beats, in order, zero-extended by the echo stub.
    logic [31:0] exp_in[$];
    int o_start, l_start, lyr0, done0, runs0, feed_to, done_to;
    logic rdy_after;

    task automatic feed(input int n, input int pat, input logic [31:0] base);
        int acc = 0;
        int cyc = 0;
        logic [31:0] d;
        d = (pat == 0) ? base : $urandom;
        while (acc < n && cyc < 400) begin
            in_vld  = (pat == 0) ? 1'b1 : (pat == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            in_data = d;
            if (in_vld && in_rdy) begin
                exp_in.push_back(d);
                acc++;
                d = (pat == 0) ? d + 32'h00020002 : $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        in_vld    = 1'b0;
        rdy_after = in_rdy;
        feed_to   = (acc < n) ? 1 : 0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (n_done == done0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        done_to = (n_done == done0) ? 1 : 0;
    endtask

    task automatic run_frame(input int pat, input logic [31:0] base, input bit drop3, input bit extra);
        stub_drop3 = drop3;
        stub_extra = extra;
        exp_in.delete();
        o_start = out_q.size();
        l_start = last_idx.size();
        lyr0    = n_lyr;
        done0   = n_done;
        runs0   = rst_runs.size();
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        feed(FL, pat, base);
        wait_done();
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        int hi = 0;
        rst = 1'b1; start = 1'b0; cont = 1'b0; in_vld = 1'b0; in_data = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (lyr_rst === 1'b1) hi++;
        end
        total++;
        if (hi !== 10) begin bad++; $display("FAIL rst_lyr_rst_during: got %0d of 10 cycles high", hi); end
        total++;
        if (in_rdy !== 1'b0 || out_vld !== 1'b0 || frame_done !== 1'b0 || lyr_vld_in !== 1'b0) begin
            bad++; $display("FAIL rst_outputs: in_rdy=%b out_vld=%b frame_done=%b lyr_vld_in=%b want 0",
                            in_rdy, out_vld, frame_done, lyr_vld_in);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (rst_runs.size() != 1 || rst_runs[0] != RC) begin
            bad++; $display("FAIL rst_tail: runs=%0d first=%0d want 1 run of %0d", rst_runs.size(),
                            (rst_runs.size() > 0) ? rst_runs[0] : -1, RC);
        end
        total++;
        if (in_rdy !== 1'b0 || busy !== 1'b0 || lyr_rst !== 1'b0 || out_q.size() != 0 || n_done != 0) begin
            bad++; $display("FAIL idle_after_rst: in_rdy=%b busy=%b lyr_rst=%b outs=%0d done=%0d want all 0",
                            in_rdy, busy, lyr_rst, out_q.size(), n_done);
        end
        total++;
        if (out_data !== '0 || lyr_data_in !== '0 || out_last !== 1'b0 || frame_err !== 1'b0) begin
            bad++; $display("FAIL rst_data_regs: out_data=%0h lyr_data_in=%0h want 0", out_data[31:0], lyr_data_in);
        end
    endtask

    task automatic test_single_frame();
        int nbad = 0;
        cont = 1'b0;
        run_frame(0, 32'h00010002, 1'b0, 1'b0);
        total++;
        if (feed_to != 0 || done_to != 0) begin bad++; $display("FAIL single_timeout: feed=%0d done=%0d want 0", feed_to, done_to); end
        total++;
        if (n_lyr - lyr0 != FL) begin bad++; $display("FAIL single_lyr_vld: got %0d want %0d", n_lyr - lyr0, FL); end
        total++;
        if (out_q.size() - o_start != OPF) begin bad++; $display("FAIL single_out_cnt: got %0d want %0d", out_q.size() - o_start, OPF); end
        for (int i = 0; i < OPF && i < exp_in.size() && o_start + i < out_q.size(); i++)
            if (out_q[o_start+i] !== exp_in[i]) nbad++;
        total++;
        if (nbad != 0 || hi_nz != 0) begin bad++; $display("FAIL single_data: %0d words differ, %0d nonzero upper, want 0", nbad, hi_nz); end
        total++;
        if (last_idx.size() - l_start != 1 || last_idx[$] != o_start + OPF) begin
            bad++; $display("FAIL single_last: count=%0d pos=%0d want 1 at %0d", last_idx.size() - l_start,
                            (last_idx.size() > 0) ? last_idx[$] : -1, o_start + OPF);
        end
        total++;
        if (out_q.size() >= o_start + OPF && out_q[o_start+OPF-1] !== 32'h001F0020) begin
            bad++; $display("FAIL single_last_data: got %08h want 001f0020", out_q[o_start+OPF-1]);
        end
        total++;
        if (n_done - done0 != 1 || last_err !== 1'b0) begin
            bad++; $display("FAIL single_done: dones=%0d err=%b want 1 and 0", n_done - done0, last_err);
        end
        total++;
        if (rst_runs.size() != runs0 + 1 || rst_runs[$] != RC || busy !== 1'b0) begin
            bad++; $display("FAIL single_flush: runs=%0d len=%0d busy=%b want 1 run of %0d then idle",
                            rst_runs.size() - runs0, rst_runs[$], busy, RC);
        end
    endtask

    task automatic test_bursty();
        int nbad = 0;
        run_frame(1, 32'h0, 1'b0, 1'b0);
        total++;
        if (feed_to != 0 || exp_in.size() != FL || rdy_after !== 1'b0) begin
            bad++; $display("FAIL bursty_accept: accepted=%0d rdy_after=%b to=%0d want %0d and 0", exp_in.size(), rdy_after, feed_to, FL);
        end
        for (int i = 0; i < exp_in.size() && o_start + i < out_q.size(); i++)
            if (out_q[o_start+i] !== exp_in[i]) nbad++;
        total++;
        if (out_q.size() - o_start != OPF || nbad != 0 || last_err !== 1'b0) begin
            bad++; $display("FAIL bursty_out: count=%0d bad_words=%0d err=%b want %0d 0 0", out_q.size() - o_start, nbad, last_err, OPF);
        end
    endtask

    task automatic test_timeout();
        int nbad = 0;
        run_frame(2, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < OPF - 3 && o_start + i < out_q.size(); i++)
            if (out_q[o_start+i] !== exp_in[i]) nbad++;
        total++;
        if (out_q.size() - o_start != OPF - 3 || nbad != 0) begin
            bad++; $display("FAIL tmo_out: count=%0d bad_words=%0d want %0d 0", out_q.size() - o_start, nbad, OPF - 3);
        end
        total++;
        if (done_to != 0 || last_err !== 1'b1 || last_drain != TMO) begin
            bad++; $display("FAIL tmo_done: to=%0d err=%b drain_cycles=%0d want 0 1 %0d", done_to, last_err, last_drain, TMO);
        end
        total++;
        if (last_idx.size() != l_start) begin bad++; $display("FAIL tmo_last: got %0d out_last want 0", last_idx.size() - l_start); end
    endtask

    task automatic test_overrun();
        int nbad = 0;
        run_frame(2, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < OPF && o_start + i < out_q.size(); i++)
            if (out_q[o_start+i] !== exp_in[i]) nbad++;
        total++;
        if (out_q.size() - o_start != OPF || nbad != 0) begin
            bad++; $display("FAIL ovr_out: count=%0d bad_words=%0d want %0d 0", out_q.size() - o_start, nbad, OPF);
        end
        total++;
        if (done_to != 0 || last_err !== 1'b1 || last_idx.size() - l_start != 1) begin
            bad++; $display("FAIL ovr_err: to=%0d err=%b lasts=%0d want 0 1 1", done_to, last_err, last_idx.size() - l_start);
        end
    endtask

    task automatic test_cont_reset();
        stub_drop3 = 1'b0;
        stub_extra = 1'b0;
        cont       = 1'b1;
        exp_in.delete();
        o_start = out_q.size();
        done0   = n_done;
        runs0   = rst_runs.size();
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        feed(FL, 0, $urandom);
        wait_done();
        total++;
        if (done_to != 0 || last_err !== 1'b0 || out_q.size() - o_start != OPF) begin
            bad++; $display("FAIL cont_frame1: to=%0d err=%b outs=%0d want 0 0 %0d", done_to, last_err, out_q.size() - o_start, OPF);
        end
        feed(7, 0, $urandom);
        total++;
        if (feed_to != 0 || rst_runs.size() != runs0 + 1 || rst_runs[$] != RC) begin
            bad++; $display("FAIL cont_gap: to=%0d runs=%0d len=%0d want 0 1 %0d", feed_to, rst_runs.size() - runs0, rst_runs[$], RC);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (n_done - done0 != 1) begin bad++; $display("FAIL cont_abort_done: dones=%0d want 1", n_done - done0); end
        total++;
        if (rst_runs.size() != runs0 + 2 || rst_runs[$] != RC || busy !== 1'b0 || in_rdy !== 1'b0) begin
            bad++; $display("FAIL cont_abort_idle: runs=%0d len=%0d busy=%b in_rdy=%b want 2 %0d 0 0",
                            rst_runs.size() - runs0, rst_runs[$], busy, in_rdy, RC);
        end
        cont = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_bursty();
        test_timeout();
        test_overrun();
        test_cont_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time limit want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
